// File: rtl/booth_acc.sv
// ---------------------------------------------------------------------------
// booth_acc
//   MAC back-end for the boothmul datapath. Accepts N signed products over a
//   valid/ready handshake, sums them into a wider signed accumulator, and
//   presents the completed sum on a second valid/ready handshake before
//   restarting.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both 1. A producer holds valid and data until that
//   edge. p_ready depends only on state and clr, never on p_valid.
//   acc_valid, once raised, stays high with acc stable until acc_ready.
//
// Configuration macro:
//   BOOTH_ACC_SAT_EN  defined   -> acc saturates on overflow
//                     undefined -> acc wraps modulo 2^AW
//   ovf is set identically in both builds.
//
// Parameters:
//   PW  product width (signed), AW accumulator width (AW >= PW), N >= 1.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear, highest priority after rst
//   p_valid    product valid
//   p_ready    accumulator can accept a product (combinational)
//   p          signed product
//   acc_valid  acc holds a completed N-term sum
//   acc_ready  consumer accepts acc
//   acc        signed accumulated sum
//   ovf        sticky overflow flag for the current sum
//   cnt        products accepted into the current sum
//   dbg_state  FSM state (0 = ACCUM, 1 = HOLD)
// ---------------------------------------------------------------------------
module booth_acc #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int N  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   p_valid,
    output logic                   p_ready,
    input  logic [PW-1:0]          p,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic [AW-1:0]          acc,
    output logic                   ovf,
    output logic [$clog2(N+1)-1:0] cnt,
    output logic                   dbg_state
);

    localparam int CW = $clog2(N+1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic          take;
    logic          restart;
    logic [CW-1:0] cnt_inc;
    logic [AW:0]   p_ext;
    logic [AW:0]   sum;
    logic          ovf_now;
    logic [AW-1:0] acc_add;

    // -----------------------------------------------------------------------
    // Add arithmetic: one guard bit so overflow shows as top-two-bit mismatch
    // -----------------------------------------------------------------------
    assign take    = p_valid & p_ready;
    assign restart = (state_q == HOLD) & acc_ready;
    assign cnt_inc = cnt + CW'(1);
    assign p_ext   = {{(AW+1-PW){p[PW-1]}}, p};
    assign sum     = {acc[AW-1], acc} + p_ext;
    assign ovf_now = sum[AW] ^ sum[AW-1];

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    // The guard bit carries the true sign of the overflowed sum.
    always_comb begin
        acc_add = sum[AW-1:0];
        if (ovf_now) begin
            acc_add = sum[AW] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        acc_add = sum[AW-1:0];
    end
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: if (take && (cnt_inc == CW'(N))) state_d = HOLD;
                HOLD:  if (acc_ready)                   state_d = ACCUM;
                default:                                state_d = ACCUM;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. acc_valid is the state flop itself, so it is registered.
    // -----------------------------------------------------------------------
    always_comb begin
        p_ready   = (state_q == ACCUM) & ~clr;
        acc_valid = (state_q == HOLD);
        dbg_state = state_q;
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr || restart) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (take) begin
            acc <= acc_add;
            cnt <= cnt_inc;
            if (ovf_now) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_acc.sv
module tb_booth_acc;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for all three instances
    logic        clr       = 1'b0;
    logic        p_valid   = 1'b0;
    logic [15:0] p         = '0;
    logic        acc_ready = 1'b0;

    // u0: default N=4, AW=24
    logic        u0_p_ready, u0_acc_valid, u0_ovf, u0_dbg;
    logic [23:0] u0_acc;
    logic [2:0]  u0_cnt;
    // u1: AW=16 for overflow
    logic        u1_p_ready, u1_acc_valid, u1_ovf, u1_dbg;
    logic [15:0] u1_acc;
    logic [2:0]  u1_cnt;
    // u2: N=1
    logic        u2_p_ready, u2_acc_valid, u2_ovf, u2_dbg;
    logic [23:0] u2_acc;
    logic [0:0]  u2_cnt;

    booth_acc #(.PW(16), .AW(24), .N(4)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .p_valid(p_valid), .p_ready(u0_p_ready),
        .p(p), .acc_valid(u0_acc_valid), .acc_ready(acc_ready), .acc(u0_acc),
        .ovf(u0_ovf), .cnt(u0_cnt), .dbg_state(u0_dbg));

    booth_acc #(.PW(16), .AW(16), .N(4)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .p_valid(p_valid), .p_ready(u1_p_ready),
        .p(p), .acc_valid(u1_acc_valid), .acc_ready(acc_ready), .acc(u1_acc),
        .ovf(u1_ovf), .cnt(u1_cnt), .dbg_state(u1_dbg));

    booth_acc #(.PW(16), .AW(24), .N(1)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .p_valid(p_valid), .p_ready(u2_p_ready),
        .p(p), .acc_valid(u2_acc_valid), .acc_ready(acc_ready), .acc(u2_acc),
        .ovf(u2_ovf), .cnt(u2_cnt), .dbg_state(u2_dbg));

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // u0 vector table
    typedef struct {
        logic pv;
        int   pval;
        logic ar;
        logic cl;
        logic epr;   // p_ready in the drive cycle
        logic eav;   // acc_valid after the edge
        int   eacc;
        int   ecnt;
        logic eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic pv, int pval, logic ar, logic cl, logic epr,
                                logic eav, int eacc, int ecnt, logic eovf);
        vec_t v;
        v.pv = pv; v.pval = pval; v.ar = ar; v.cl = cl; v.epr = epr;
        v.eav = eav; v.eacc = eacc; v.ecnt = ecnt; v.eovf = eovf;
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic drive(input logic pv, input int pval, input logic ar, input logic cl);
        @(negedge clk);
        p_valid   = pv;
        p         = 16'(pval);
        acc_ready = ar;
        clr       = cl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        p_valid = 1'b0; clr = 1'b0; acc_ready = 1'b0; p = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic u0_outs(input string tag, input logic eav, input int eacc,
                           input int ecnt, input logic eovf);
        check({tag, ".acc_valid"}, int'(u0_acc_valid), int'(eav));
        check({tag, ".acc"}, int'($signed(u0_acc)), eacc);
        check({tag, ".cnt"}, int'(u0_cnt), ecnt);
        check({tag, ".ovf"}, int'(u0_ovf), int'(eovf));
    endtask

    initial begin
        // ---- basic sum (one result, acc_valid for one cycle)
        vecs.push_back(mk(1,   256, 1, 0, 1, 0,   256, 1, 0));
        vecs.push_back(mk(1, -3424, 1, 0, 1, 0, -3168, 2, 0));
        vecs.push_back(mk(1,     0, 1, 0, 1, 0, -3168, 3, 0));
        vecs.push_back(mk(1,     1, 1, 0, 1, 1, -3167, 4, 0));
        vecs.push_back(mk(0,     0, 1, 0, 0, 0,     0, 0, 0));
        // ---- gapped input, then backpressure on the result
        vecs.push_back(mk(1,  1, 0, 0, 1, 0,  1, 1, 0));
        vecs.push_back(mk(0, 99, 0, 0, 1, 0,  1, 1, 0));
        vecs.push_back(mk(1,  2, 0, 0, 1, 0,  3, 2, 0));
        vecs.push_back(mk(0, 99, 0, 0, 1, 0,  3, 2, 0));
        vecs.push_back(mk(1,  3, 0, 0, 1, 0,  6, 3, 0));
        vecs.push_back(mk(0, 99, 0, 0, 1, 0,  6, 3, 0));
        vecs.push_back(mk(1,  4, 0, 0, 1, 1, 10, 4, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 5, 0, 0, 0, 1, 10, 4, 0));
        vecs.push_back(mk(0,  0, 1, 0, 0, 0,  0, 0, 0));
        // ---- clr mid-sum with a product presented
        vecs.push_back(mk(1,   7, 0, 0, 1, 0,  7, 1, 0));
        vecs.push_back(mk(1,   8, 0, 0, 1, 0, 15, 2, 0));
        vecs.push_back(mk(1, 100, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1,   3, 0, 0, 1, 0,  3, 1, 0));

        // ---- reset state
        #1;
        check("rst.p_ready", int'(u0_p_ready), 1);
        u0_outs("rst", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- table
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].pv, vecs[i].pval, vecs[i].ar, vecs[i].cl);
            #1;
            check({tag, ".p_ready"}, int'(u0_p_ready), int'(vecs[i].epr));
            @(posedge clk);
            #1;
            u0_outs(tag, vecs[i].eav, vecs[i].eacc, vecs[i].ecnt, vecs[i].eovf);
        end

        // ---- async reset mid-sum: values change before any clock edge
        do_reset();
        drive(1, 11, 0, 0);
        drive(1, 22, 0, 0);
        @(posedge clk); #1;
        u0_outs("prerst", 0, 33, 2, 0);
        #2;                       // mid-cycle, well away from either edge
        rst = 1'b1;
        #1;
        u0_outs("asyncrst", 0, 0, 0, 0);
        check("asyncrst.p_ready", int'(u0_p_ready), 1);
        @(negedge clk);
        p_valid = 1'b0;
        rst = 1'b0;

        // ---- overflow on AW=16: four x 16384, result held with acc_ready=0
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 16384, 0, 0);
        drive(0, 0, 0, 0);
        #1;
        check("ovf.acc_valid", int'(u1_acc_valid), 1);
`ifdef BOOTH_ACC_SAT_EN
        check("ovf.acc", int'($signed(u1_acc)), 32767);
`else
        check("ovf.acc", int'($signed(u1_acc)), 0);
`endif
        check("ovf.ovf", int'(u1_ovf), 1);
        check("ovf.cnt", int'(u1_cnt), 4);
        drive(0, 0, 1, 0);
        @(posedge clk); #1;
        check("ovf.restart_ovf", int'(u1_ovf), 0);
        check("ovf.restart_acc", int'($signed(u1_acc)), 0);
        drive(1, -100, 0, 0);
        @(posedge clk); #1;
        check("ovf.newsum_acc", int'($signed(u1_acc)), -100);
        check("ovf.newsum_ovf", int'(u1_ovf), 0);

        // ---- negative overflow on AW=16: -16384 x 3
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, -16384, 0, 0);
        @(posedge clk); #1;
`ifdef BOOTH_ACC_SAT_EN
        check("novf.acc", int'($signed(u1_acc)), -32768);
`else
        check("novf.acc", int'($signed(u1_acc)), 16384);
`endif
        check("novf.ovf", int'(u1_ovf), 1);
        check("novf.cnt", int'(u1_cnt), 3);

        // ---- N=1 stream: -5 then 7, one HOLD cycle between
        do_reset();
        drive(1, -5, 1, 0);
        #1;
        check("n1.a.p_ready", int'(u2_p_ready), 1);
        @(posedge clk); #1;
        check("n1.a.acc_valid", int'(u2_acc_valid), 1);
        check("n1.a.acc", int'($signed(u2_acc)), -5);
        check("n1.a.cnt", int'(u2_cnt), 1);
        drive(1, 7, 1, 0);
        #1;
        check("n1.hold.p_ready", int'(u2_p_ready), 0);
        @(posedge clk); #1;
        check("n1.hold.acc_valid", int'(u2_acc_valid), 0);
        check("n1.hold.acc", int'($signed(u2_acc)), 0);
        drive(1, 7, 1, 0);
        #1;
        check("n1.b.p_ready", int'(u2_p_ready), 1);
        @(posedge clk); #1;
        check("n1.b.acc_valid", int'(u2_acc_valid), 1);
        check("n1.b.acc", int'($signed(u2_acc)), 7);
        check("n1.b.ovf", int'(u2_ovf), 0);
        drive(0, 0, 1, 0);

        // ---- final report
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
